high_score_tracker: RTL

//  Sits downstream of the score counter and game controller in tt_um_uwasic_dinogame.

---
 rtl/dino_pkg.sv | 22 ++
 rtl/bcd_digit_cmp.sv | 16 +
 rtl/high_score_tracker.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/dino_pkg.sv
// Shared types and helpers for the dino game score path.
package dino_pkg;

  localparam int BCD_W          = 4;
  localparam int BCD_MAX_DIGITS = 8;
  localparam int BCD_MAX_W      = BCD_W * BCD_MAX_DIGITS;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUNNING   = 3'd1,
    COMPARE   = 3'd2,
    UPDATE    = 3'd3,
    CELEBRATE = 3'd4
  } hs_state_t;

  // Callers zero-extend narrower score vectors to BCD_MAX_W before calling.
  function automatic logic [BCD_W-1:0] bcd_digit(input logic [BCD_MAX_W-1:0] vec,
                                                 input int idx);
    return vec[idx*BCD_W +: BCD_W];
  endfunction

endpackage

// File: rtl/bcd_digit_cmp.sv
// Unsigned 4-bit magnitude compare of one score digit against one best-score digit.
module bcd_digit_cmp
  import dino_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/high_score_tracker.sv
// Snapshots the run score on game over and keeps the best score via an MSD-first serial compare.
// Define HS_BLINK_EN to build the post-record CELEBRATE blink; otherwise hs_blink is tied low.
module high_score_tracker
  import dino_pkg::*;
#(
  parameter int NUM_DIGITS    = 5,
  parameter int BLINK_TICKS   = 5,
  parameter int BLINK_TOGGLES = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        game_tick,
  input  logic                        game_start,
  input  logic                        game_over,
  input  logic [BCD_W*NUM_DIGITS-1:0] score,
  output logic [BCD_W*NUM_DIGITS-1:0] hi_score,
  output logic                        new_record,
  output logic                        hs_blink,
  output logic                        busy
);

  localparam int SCORE_W = BCD_W * NUM_DIGITS;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_DIGITS - 1);

  hs_state_t            state;
  logic [SCORE_W-1:0]   snapshot;
  logic [IDX_W-1:0]     idx;
  logic                 pending_start;
  logic                 start_req;
  logic [BCD_MAX_W-1:0] snap_ext;
  logic [BCD_MAX_W-1:0] hi_ext;
  logic [BCD_W-1:0]     snap_digit;
  logic [BCD_W-1:0]     hi_digit;
  logic                 dig_gt;
  logic                 dig_lt;
  logic                 dig_eq;

`ifdef HS_BLINK_EN
  localparam int TICK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int TOG_W  = (BLINK_TOGGLES > 1) ? $clog2(BLINK_TOGGLES) : 1;
  logic [TICK_W-1:0] tick_cnt;
  logic [TOG_W-1:0]  tog_cnt;
`else
  assign hs_blink = 1'b0;
`endif

  always_comb begin
    snap_ext                = '0;
    hi_ext                  = '0;
    snap_ext[SCORE_W-1:0]   = snapshot;
    hi_ext[SCORE_W-1:0]     = hi_score;
  end

  assign snap_digit = bcd_digit(snap_ext, int'(idx));
  assign hi_digit   = bcd_digit(hi_ext, int'(idx));

  bcd_digit_cmp u_digit_cmp (
    .a  (snap_digit),
    .b  (hi_digit),
    .gt (dig_gt),
    .lt (dig_lt),
    .eq (dig_eq)
  );

  // A start arriving on the very cycle a comparison finishes counts as pending too.
  assign start_req = pending_start | game_start;
  assign busy      = (state == COMPARE) || (state == UPDATE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      hi_score      <= '0;
      new_record    <= 1'b0;
      snapshot      <= '0;
      idx           <= IDX_TOP;
      pending_start <= 1'b0;
`ifdef HS_BLINK_EN
      hs_blink      <= 1'b0;
      tick_cnt      <= '0;
      tog_cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (game_start) begin
            state      <= RUNNING;
            new_record <= 1'b0;
          end
        end

        RUNNING: begin
          if (game_over) begin
            state         <= COMPARE;
            snapshot      <= score;
            idx           <= IDX_TOP;
            pending_start <= game_start;
          end
        end

        COMPARE: begin
          if (game_start) begin
            pending_start <= 1'b1;
          end
          if (dig_gt) begin
            state <= UPDATE;
          end else if (dig_lt || (dig_eq && (idx == '0))) begin
            if (start_req) begin
              state         <= RUNNING;
              pending_start <= 1'b0;
              new_record    <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            idx <= idx - 1'b1;
          end
        end

        UPDATE: begin
          hi_score <= snapshot;
          if (start_req) begin
            state         <= RUNNING;
            pending_start <= 1'b0;
            new_record    <= 1'b0;
          end else begin
            new_record <= 1'b1;
`ifdef HS_BLINK_EN
            state      <= CELEBRATE;
`else
            state      <= IDLE;
`endif
          end
        end

`ifdef HS_BLINK_EN
        // Blink phase advances only on game ticks; a new run aborts it immediately.
        CELEBRATE: begin
          if (game_start) begin
            state      <= RUNNING;
            new_record <= 1'b0;
            hs_blink   <= 1'b0;
            tick_cnt   <= '0;
            tog_cnt    <= '0;
          end else if (game_tick) begin
            if (tick_cnt == TICK_W'(BLINK_TICKS - 1)) begin
              tick_cnt <= '0;
              if (tog_cnt == TOG_W'(BLINK_TOGGLES - 1)) begin
                tog_cnt  <= '0;
                hs_blink <= 1'b0;
                state    <= IDLE;
              end else begin
                tog_cnt  <= tog_cnt + 1'b1;
                hs_blink <= ~hs_blink;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
`endif

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
